// File: rtl/cfg_discovery_unit.sv
// rtl/cfg_discovery_unit.sv - read-only indexed view of the elaborated core configuration
// Words are elaboration-time constants; only acceptance, burst sequencing and handshake are stateful.

package config_pkg;

   typedef struct packed {
      logic [31:0] XLEN;
      logic        RVA;
      logic        RVC;
      logic        RVD;
      logic        RVF;
      logic        RVH;
      logic        RVS;
      logic        RVU;
      logic        RVV;
      logic [31:0] IcacheByteSize;
      logic [31:0] IcacheSetAssoc;
      logic [31:0] IcacheLineWidth;
      logic [31:0] DcacheByteSize;
      logic [31:0] DcacheSetAssoc;
      logic [31:0] DcacheLineWidth;
      logic [31:0] NrScoreboardEntries;
      logic [31:0] NrPMPEntries;
      logic [31:0] RASDepth;
      logic [31:0] BTBEntries;
      logic [31:0] BHTEntries;
      logic        MmuPresent;
      logic        DebugEn;
      logic        PerfCounterEn;
      logic [63:0] HaltAddress;
      logic [63:0] ExceptionAddress;
      logic [63:0] DmBaseAddress;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32'd64, default: '0};

endpackage

module cfg_discovery_unit #(
   parameter config_pkg::cva6_cfg_t CVA6Cfg  = config_pkg::cva6_cfg_empty,
   parameter int unsigned           NumWords = 7
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [2:0]              req_index_i,
   input  logic [2:0]              req_len_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [CVA6Cfg.XLEN-1:0] rsp_data_o,
   output logic                    rsp_err_o,
   output logic                    rsp_last_o
);

   localparam int unsigned XLEN = CVA6Cfg.XLEN;

   typedef enum logic {
      ST_IDLE,
      ST_STREAM
   } state_t;

   state_t            r_state;
   logic              r_req_ready;
   logic              r_rsp_valid;
   logic [XLEN-1:0]   r_rsp_data;
   logic              r_rsp_err;
   logic              r_rsp_last;
   logic [3:0]        r_cur_idx;
   logic [2:0]        r_remaining;

   logic [3:0]        w_acc_idx;
   logic [3:0]        w_next_idx;
   logic [63:0]       w_acc_word;
   logic [63:0]       w_next_word;
   logic              w_acc_err;
   logic              w_next_err;

   function automatic logic [63:0] word_at(input logic [3:0] idx);
      logic [63:0] w;
      w = '0;
      case (idx)
         4'd0: begin
            if (XLEN == 32) w[31:30] = 2'd1;
            else            w[63:62] = 2'd2;
            w[0]  = CVA6Cfg.RVA;
            w[2]  = CVA6Cfg.RVC;
            w[3]  = CVA6Cfg.RVD;
            w[5]  = CVA6Cfg.RVF;
            w[7]  = CVA6Cfg.RVH;
            w[8]  = 1'b1;
            w[12] = 1'b1;
            w[18] = CVA6Cfg.RVS;
            w[20] = CVA6Cfg.RVU;
            w[21] = CVA6Cfg.RVV;
         end
         4'd1: begin
            w[31:0]  = CVA6Cfg.IcacheByteSize;
            w[39:32] = CVA6Cfg.IcacheSetAssoc[7:0];
            w[55:40] = CVA6Cfg.IcacheLineWidth[15:0];
         end
         4'd2: begin
            w[31:0]  = CVA6Cfg.DcacheByteSize;
            w[39:32] = CVA6Cfg.DcacheSetAssoc[7:0];
            w[55:40] = CVA6Cfg.DcacheLineWidth[15:0];
         end
         4'd3: begin
            w[7:0]   = CVA6Cfg.NrScoreboardEntries[7:0];
            w[15:8]  = CVA6Cfg.NrPMPEntries[7:0];
            w[23:16] = CVA6Cfg.RASDepth[7:0];
            w[39:24] = CVA6Cfg.BTBEntries[15:0];
            w[55:40] = CVA6Cfg.BHTEntries[15:0];
            w[56]    = CVA6Cfg.MmuPresent;
            w[57]    = CVA6Cfg.DebugEn;
            w[58]    = CVA6Cfg.PerfCounterEn;
         end
         4'd4:    w = CVA6Cfg.HaltAddress;
         4'd5:    w = CVA6Cfg.ExceptionAddress;
         4'd6:    w = CVA6Cfg.DmBaseAddress;
         default: w = '0;
      endcase
      return w;
   endfunction

   function automatic logic idx_err(input logic [3:0] idx);
      return 32'(idx) >= NumWords;
   endfunction

   // Out-of-range words read as zero regardless of what the map would hold.
   assign w_acc_idx   = {1'b0, req_index_i};
   assign w_next_idx  = r_cur_idx + 4'd1;
   assign w_acc_err   = idx_err(w_acc_idx);
   assign w_next_err  = idx_err(w_next_idx);
   assign w_acc_word  = w_acc_err  ? 64'd0 : word_at(w_acc_idx);
   assign w_next_word = w_next_err ? 64'd0 : word_at(w_next_idx);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state     <= ST_IDLE;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
         r_rsp_last  <= 1'b0;
         r_cur_idx   <= '0;
         r_remaining <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid_i) begin
                  r_state     <= ST_STREAM;
                  r_req_ready <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_cur_idx   <= w_acc_idx;
                  r_remaining <= req_len_i;
                  r_rsp_data  <= w_acc_word[XLEN-1:0];
                  r_rsp_err   <= w_acc_err;
                  r_rsp_last  <= (req_len_i == 3'd0);
               end
            end
            ST_STREAM: begin
               if (rsp_ready_i) begin
                  if (r_remaining != 3'd0) begin
                     r_cur_idx   <= w_next_idx;
                     r_remaining <= r_remaining - 3'd1;
                     r_rsp_data  <= w_next_word[XLEN-1:0];
                     r_rsp_err   <= w_next_err;
                     r_rsp_last  <= (r_remaining == 3'd1);
                  end else begin
                     r_state     <= ST_IDLE;
                     r_req_ready <= 1'b1;
                     r_rsp_valid <= 1'b0;
                     r_rsp_data  <= '0;
                     r_rsp_err   <= 1'b0;
                     r_rsp_last  <= 1'b0;
                  end
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_req_ready <= 1'b1;
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready_o = r_req_ready;
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_data_o  = r_rsp_data;
   assign rsp_err_o   = r_rsp_err;
   assign rsp_last_o  = r_rsp_last;

endmodule

// File: tb/tb_cfg_discovery_unit.sv
// tb/tb_cfg_discovery_unit.sv - directed bench for cfg_discovery_unit with the cv64a6 polara configuration

module tb_cfg_discovery_unit;

   localparam config_pkg::cva6_cfg_t POLARA = '{
      XLEN: 32'd64,
      RVA: 1'b1, RVC: 1'b1, RVD: 1'b1, RVF: 1'b1, RVH: 1'b0,
      RVS: 1'b1, RVU: 1'b1, RVV: 1'b1,
      IcacheByteSize: 32'd16384, IcacheSetAssoc: 32'd4, IcacheLineWidth: 32'd128,
      DcacheByteSize: 32'd32768, DcacheSetAssoc: 32'd8, DcacheLineWidth: 32'd128,
      NrScoreboardEntries: 32'd8, NrPMPEntries: 32'd8, RASDepth: 32'd2,
      BTBEntries: 32'd32, BHTEntries: 32'd128,
      MmuPresent: 1'b1, DebugEn: 1'b1, PerfCounterEn: 1'b1,
      HaltAddress: 64'h800, ExceptionAddress: 64'h808, DmBaseAddress: 64'h0
   };

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_index;
   logic [2:0]  req_len;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_data;
   logic        rsp_err;
   logic        rsp_last;

   int n_checks = 0;
   int n_err    = 0;

   logic [63:0] exp_words [0:7];

   cfg_discovery_unit #(
      .CVA6Cfg  (POLARA),
      .NumWords (7)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_index_i (req_index),
      .req_len_i   (req_len),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_data_o  (rsp_data),
      .rsp_err_o   (rsp_err),
      .rsp_last_o  (rsp_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   task automatic chk_beat(input string tag, input logic [63:0] data, input logic err,
                           input logic last);
      chk({tag, ".valid"}, {63'd0, rsp_valid}, 64'd1);
      chk({tag, ".data"},  rsp_data, data);
      chk({tag, ".err"},   {63'd0, rsp_err}, {63'd0, err});
      chk({tag, ".last"},  {63'd0, rsp_last}, {63'd0, last});
      chk({tag, ".rdy"},   {63'd0, req_ready}, 64'd0);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".valid"}, {63'd0, rsp_valid}, 64'd0);
      chk({tag, ".rdy"},   {63'd0, req_ready}, 64'd1);
   endtask

   initial begin
      exp_words[0] = 64'h8000_0000_0034_112D;
      exp_words[1] = 64'h0000_8004_0000_4000;
      exp_words[2] = 64'h0000_8008_0000_8000;
      exp_words[3] = 64'h0700_8000_2002_0808;
      exp_words[4] = 64'h800;
      exp_words[5] = 64'h808;
      exp_words[6] = 64'h0;
      exp_words[7] = 64'h0;

      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_index = 3'd0;
      req_len   = 3'd0;
      rsp_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      chk_idle("reset");
      chk("reset.data", rsp_data, 64'd0);
      chk("reset.err",  {63'd0, rsp_err}, 64'd0);
      chk("reset.last", {63'd0, rsp_last}, 64'd0);

      // single read of word 0
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_index = 3'd0;
      req_len   = 3'd0;
      step();
      req_valid = 1'b0;
      chk_beat("single", exp_words[0], 1'b0, 1'b1);
      step();
      chk_idle("single.after");

      // burst crossing into the out-of-range word
      req_valid = 1'b1;
      req_index = 3'd1;
      req_len   = 3'd6;
      step();
      req_valid = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         chk_beat($sformatf("burst.w%0d", i), exp_words[i], (i == 7), (i == 7));
         step();
      end
      chk_idle("burst.after");

      // backpressure; a request offered during the stall must be ignored
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_index = 3'd4;
      req_len   = 3'd1;
      step();
      req_index = 3'd0;
      req_len   = 3'd0;
      for (int i = 0; i < 5; i++) begin
         chk_beat($sformatf("bp.hold%0d", i), 64'h800, 1'b0, 1'b0);
         step();
      end
      req_valid = 1'b0;
      chk_beat("bp.hold5", 64'h800, 1'b0, 1'b0);
      rsp_ready = 1'b1;
      step();
      chk_beat("bp.second", 64'h808, 1'b0, 1'b1);
      step();
      chk_idle("bp.after");

      // maximum indices: all beats out of range, no wrap
      req_valid = 1'b1;
      req_index = 3'd7;
      req_len   = 3'd7;
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk_beat($sformatf("max.b%0d", i), 64'd0, 1'b1, (i == 7));
         step();
      end
      chk_idle("max.after");

      // reset in the middle of a burst
      req_valid = 1'b1;
      req_index = 3'd0;
      req_len   = 3'd5;
      step();
      req_valid = 1'b0;
      chk_beat("mid.b0", exp_words[0], 1'b0, 1'b0);
      step();
      chk_beat("mid.b1", exp_words[1], 1'b0, 1'b0);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk_idle("mid.reset");
      chk("mid.reset.data", rsp_data, 64'd0);
      req_valid = 1'b1;
      req_index = 3'd5;
      req_len   = 3'd0;
      step();
      req_valid = 1'b0;
      chk_beat("mid.new", 64'h808, 1'b0, 1'b1);
      step();
      chk_idle("mid.new.after");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
